multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath. Sequences one instruction
//  over 3-5 states: fetch, decode, execute, memory, writeback. Drives datapath
//  select/enable lines, waits on a memory ready handshake and bounds that wait.
//  Sits beside the single-cycle opcode decoder; consumes the same 6-bit opcode.
// PARAMETERS
//  WAIT_LIMIT  15  max cycles to wait for mem_ready in any memory state (1..15)
//  CNT_W       4   width of wait counter; must hold WAIT_LIMIT
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high reset
//  opcode       in   6  instruction [31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag, sampled in BRANCH
//  mem_ready    in   1  memory completes access this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_c   out  1  PC load if zero (beq)
//  i_or_d       out  1  0=PC addresses memory, 1=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  load instruction register
//  mem_to_reg   out  1  1=write MDR to regfile, 0=ALUOut
//  reg_dst      out  1  1=rd, 0=rt
//  reg_write    out  1  regfile write enable
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B 01=const 4 10=signext 11=signext<<2
//  alu_op       out  2  00=add 01=sub 10=funct-driven
//  pc_source    out  2  00=ALU 01=ALUOut 10=jump target
//  state        out  4  current state code (debug)
//  illegal      out  1  sticky: unsupported opcode decoded
//  mem_err      out  1  sticky: WAIT_LIMIT exceeded
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MADDR=2 MREAD=3 MWB=4 MWRITE=5 EXEC=6 RWB=7
//    BRANCH=8 JUMP=9 IEXEC=10 IWB=11; codes 12-15 unreachable, go to FETCH.
//  - Outputs are combinational from state; unlisted outputs are 0.
//  - reset: state<=FETCH, wait count<=0, illegal<=0, mem_err<=0. While reset is
//    high, all outputs read 0.
//  - FETCH: mem_read=1 i_or_d=0 alu_src_a=0 alu_src_b=01 alu_op=00 pc_source=00.
//    ir_write=pc_write=mem_ready, the only Mealy terms. Goes to DECODE on mem_ready.
//  - DECODE: alu_src_a=0 alu_src_b=11 alu_op=00. Next state by opcode:
//    000000->EXEC, 100011/101011->MADDR, 000100->BRANCH, 000010->JUMP,
//    001000->IEXEC (macro only), other->FETCH and set illegal.
//  - MADDR: alu_src_a=1 alu_src_b=10 alu_op=00. Goes to MREAD (lw) or MWRITE (sw).
//  - MREAD: mem_read=1 i_or_d=1. Goes to MWB on mem_ready.
//  - MWB: reg_write=1 mem_to_reg=1 reg_dst=0. Goes to FETCH.
//  - MWRITE: mem_write=1 i_or_d=1. Goes to FETCH on mem_ready.
//  - EXEC: alu_src_a=1 alu_src_b=00 alu_op=10, then RWB.
//  - RWB: reg_write=1 reg_dst=1 mem_to_reg=0, then FETCH.
//  - BRANCH: alu_src_a=1 alu_src_b=00 alu_op=01 pc_source=01 pc_write_c=1, then
//    FETCH. The PC load is gated by zero in the datapath, not here.
//  - JUMP: pc_write=1 pc_source=10, then FETCH.
//  - Latency: R=4, lw=5, sw=4, beq=3, j=3 cycles, each with mem_ready=1 at first sight.
//  - Wait counter: clears on entry to FETCH/MREAD/MWRITE and increments each cycle
//    mem_ready=0 in those states. When count==WAIT_LIMIT with mem_ready=0: set
//    mem_err and go to FETCH; no reg_write/pc_write is issued for that instruction.
//    mem_ready=1 in the same cycle as count==WAIT_LIMIT counts as success.
//  - opcode is sampled only in DECODE; changes at other times are ignored.
//  - reset mid-instruction aborts it immediately; no partial writes after reset.
// CONFIGURATION
//  CTRL_ADDI_EN defined: opcode 001000 is legal. IEXEC: alu_src_a=1 alu_src_b=10
//   alu_op=00, then IWB. IWB: reg_write=1 reg_dst=0 mem_to_reg=0, then FETCH.
//   Latency 4 cycles.
//  CTRL_ADDI_EN undefined: 001000 is illegal (sets illegal, goes to FETCH).
//   States 10/11 are unreachable.
// TESTING
//  1 opcode=000000, mem_ready=1: states 0,1,6,7,0. RWB has reg_write=1, reg_dst=1.
//  2 lw 100011, mem_ready low 3 cycles in MREAD: MREAD held 4 cycles, then MWB with
//    mem_to_reg=1, mem_err=0.
//  3 sw 101011, mem_ready stuck 0, WAIT_LIMIT=15: MWRITE held 16 cycles, then
//    mem_err=1 and FETCH. reg_write never asserted.
//  4 beq 000100 then j 000010: BRANCH has pc_write_c=1 pc_source=01. JUMP has
//    pc_write=1 pc_source=10. Each takes 3 cycles.
//  5 opcode=111111: DECODE->FETCH and illegal=1 until reset. Then 001000 gives
//    IEXEC/IWB with macro, illegal without.
//  6 reset asserted in MADDR: next state FETCH, all outputs 0 while reset high,
//    illegal=mem_err=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multi-cycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_c;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_c, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, mem_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_c, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, mem_err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with bounded memory-ready wait.
// Define CTRL_ADDI_EN to make opcode 001000 (addi) legal via IEXEC/IWB.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic           clk,
  input  logic           reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MREAD  = 4'd3,
    S_MWB    = 4'd4,
    S_MWRITE = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           cur_state;
  state_t           done_state;
  logic [CNT_W-1:0] cnt;
  logic             is_sw;
  logic             illegal_q;
  logic             mem_err_q;

  // Branch qualification by zero happens in the datapath.
  logic unused_zero;
  assign unused_zero = bus.zero;

  always_comb begin
    done_state = S_FETCH;
    case (cur_state)
      S_FETCH: done_state = S_DECODE;
      S_MREAD: done_state = S_MWB;
      default: done_state = S_FETCH;
    endcase
  end

  // cnt is zero whenever a wait state is entered, so it only moves inside one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      cnt       <= '0;
      is_sw     <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      case (cur_state)
        S_FETCH, S_MREAD, S_MWRITE: begin
          if (bus.mem_ready) begin
            cur_state <= done_state;
            cnt       <= '0;
          end else if (cnt == LIMIT) begin
            cur_state <= S_FETCH;
            cnt       <= '0;
            mem_err_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          is_sw <= (bus.opcode == OP_SW);
          case (bus.opcode)
            OP_RTYPE:      cur_state <= S_EXEC;
            OP_LW, OP_SW:  cur_state <= S_MADDR;
            OP_BEQ:        cur_state <= S_BRANCH;
            OP_J:          cur_state <= S_JUMP;
`ifdef CTRL_ADDI_EN
            OP_ADDI:       cur_state <= S_IEXEC;
`endif
            default: begin
              cur_state <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MADDR:  cur_state <= is_sw ? S_MWRITE : S_MREAD;
        S_EXEC:   cur_state <= S_RWB;
`ifdef CTRL_ADDI_EN
        S_IEXEC:  cur_state <= S_IWB;
`endif
        default:  cur_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the current state; FETCH adds the mem_ready-qualified loads.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_write_c = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_source  = 2'b00;
    if (!reset) begin
      case (cur_state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = 2'b11;
        S_MADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MREAD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MWRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = 2'b01;
          bus.pc_source  = 2'b01;
          bus.pc_write_c = 1'b1;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
`ifdef CTRL_ADDI_EN
        S_IEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_IWB: bus.reg_write = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.state   = reset ? 4'd0 : cur_state;
  assign bus.illegal = illegal_q & ~reset;
  assign bus.mem_err = mem_err_q & ~reset;

endmodule
